// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter: shares one single-port memory between fetch and data requesters
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int c_WAIT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int c_STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [c_WAIT_W-1:0]   c_WAIT_LOAD = c_WAIT_W'(MEM_LAT - 1);
    localparam logic [c_STARVE_W-1:0] c_SMAX      = c_STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_owner_dm;
    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic [c_STARVE_W-1:0] r_starve_cnt;

    logic w_if_forced;
    logic w_dm_wins;

    // Fetch overrides data only once it has lost STARVE_MAX times in a row.
    assign w_if_forced = if_req && (r_starve_cnt == c_SMAX);
    assign w_dm_wins   = dm_req && !w_if_forced;

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            r_state      <= S_IDLE;
            r_owner_dm   <= 1'b0;
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
            if_gnt       <= 1'b0;
            if_rdata     <= '0;
            if_valid     <= 1'b0;
            dm_gnt       <= 1'b0;
            dm_rdata     <= '0;
            dm_valid     <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
        end else begin
            mem_en   <= 1'b0;
            if_gnt   <= 1'b0;
            dm_gnt   <= 1'b0;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (dm_req || if_req) begin
                        r_state <= S_ISSUE;
                        busy    <= 1'b1;
                        mem_en  <= 1'b1;
                        if (w_dm_wins) begin
                            r_owner_dm <= 1'b1;
                            mem_addr   <= dm_addr;
                            mem_we     <= dm_we;
                            mem_wdata  <= dm_wdata;
                            dm_gnt     <= 1'b1;
                            if (if_req && (r_starve_cnt != c_SMAX))
                                r_starve_cnt <= r_starve_cnt + 1'b1;
                        end else begin
                            r_owner_dm   <= 1'b0;
                            mem_addr     <= if_addr;
                            mem_we       <= 1'b0;
                            mem_wdata    <= '0;
                            if_gnt       <= 1'b1;
                            r_starve_cnt <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= c_WAIT_LOAD;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= S_RESP;
                        if (r_owner_dm) begin
                            dm_valid <= 1'b1;
                            if (!mem_we)
                                dm_rdata <= mem_rdata;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    // Requests are deliberately ignored here so a held req cannot re-arbitrate.
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
